// File: rtl/wnaf_recoder_if.sv
// Handshake bundle between the scalar-multiplication sequencer and the wNAF recoder.
//   i_start  start pulse; i_M is sampled in the same cycle
//   i_M      unsigned scalar, N bits
//   i_ready  consumer ready for the current digit
//   o_busy   recoder is running (from the cycle after start until the last handshake)
//   o_valid  o_digit / o_nz / o_last are valid
//   o_digit  two's-complement signed digit, W bits
//   o_nz     o_digit is nonzero
//   o_last   final digit of the stream
//   o_done   one-cycle pulse after the last handshake
// Modports: master = sequencer side, slave = recoder side.
interface wnaf_recoder_if #(
    parameter int unsigned N = 255,
    parameter int unsigned W = 4
) ();
    logic         i_start;
    logic [N-1:0] i_M;
    logic         i_ready;
    logic         o_busy;
    logic         o_valid;
    logic [W-1:0] o_digit;
    logic         o_nz;
    logic         o_last;
    logic         o_done;

    modport master (
        output i_start, i_M, i_ready,
        input  o_busy, o_valid, o_digit, o_nz, o_last, o_done
    );

    modport slave (
        input  i_start, i_M, i_ready,
        output o_busy, o_valid, o_digit, o_nz, o_last, o_done
    );
endinterface

// File: rtl/wnaf_recoder.sv
// Streams the width-W non-adjacent-form recoding of an N-bit scalar, one signed digit per
// handshake, always exactly N+1 digits. Each digit d selects table entry (|d|-1)/2 with sign +/-P.
//   i_clk      rising-edge clock
//   i_rst      asynchronous active-high reset
//   bus        wnaf_recoder_if.slave: i_start/i_M in, i_ready in,
//              o_busy/o_valid/o_digit/o_nz/o_last/o_done out
// Parameters:
//   N          scalar width (assumed N >= W-1 so the working register holds a full window)
//   W          window width, 2..8 (W=2 is plain NAF)
//   MSB_FIRST  1: recode into a buffer, then emit digit N down to 0; 0: stream digit 0 upward
module wnaf_recoder #(
    parameter int unsigned N         = 255,
    parameter int unsigned W         = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    wnaf_recoder_if.slave bus
);
    localparam int unsigned   ND      = N + 1;
    localparam int unsigned   KW      = N + 2;
    localparam int unsigned   IW      = $clog2(ND);
    localparam logic [IW-1:0] IdxLast = IW'(ND - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStream,
        StRecode,
        StEmit,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  digit_q, digit_d;
    logic          valid_q, valid_d;
    logic          nz_q, nz_d;
    logic          last_q, last_d;

    logic          can_start;
    logic          hs;
    logic [KW-1:0] step_src;
    logic [KW-1:0] step_k;
    logic [KW-1:0] dig_ext;
    logic [W-1:0]  step_dig;
    logic          buf_we;
    logic [W-1:0]  buf_rd;

    assign can_start = (state_q == StIdle) || (state_q == StDone);
    assign hs        = valid_q && bus.i_ready;

    // One recoding step. When idle the step works on i_M directly so the streaming order can
    // present digit 0 in the cycle right after start. For an odd k the W-bit two's-complement
    // digit is exactly k mod 2^W, so no subtraction is needed to form it.
    always_comb begin
        step_src = can_start ? {2'b00, bus.i_M} : k_q;
        step_dig = step_src[0] ? step_src[W-1:0] : '0;
        dig_ext  = KW'(signed'(step_dig));
        step_k   = (step_src - dig_ext) >> 1;
    end

    if (MSB_FIRST) begin : g_buf
        logic [W-1:0]  buf_q [ND];
        logic [IW-1:0] rd_idx;

        // Digit storage needs no reset: nothing is read before RECODE has filled it.
        always_ff @(posedge i_clk) begin
            if (buf_we) begin
                buf_q[idx_q] <= step_dig;
            end
        end

        assign rd_idx = idx_q - IW'(1);
        assign buf_rd = buf_q[rd_idx];
    end else begin : g_nobuf
        assign buf_rd = '0;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        idx_d   = idx_q;
        digit_d = digit_q;
        valid_d = valid_q;
        nz_d    = nz_q;
        last_d  = last_q;
        buf_we  = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.i_start) begin
                    idx_d = '0;
                    if (MSB_FIRST) begin
                        state_d = StRecode;
                        k_d     = step_src;
                    end else begin
                        state_d = StStream;
                        k_d     = step_k;
                        digit_d = step_dig;
                        nz_d    = |step_dig;
                        last_d  = 1'b0;
                        valid_d = 1'b1;
                    end
                end
            end

            StStream: begin
                if (hs) begin
                    if (idx_q == IdxLast) begin
                        state_d = StDone;
                        valid_d = 1'b0;
                        digit_d = '0;
                        nz_d    = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        k_d     = step_k;
                        digit_d = step_dig;
                        nz_d    = |step_dig;
                        last_d  = (idx_q + IW'(1)) == IdxLast;
                    end
                end
            end

            StRecode: begin
                buf_we = 1'b1;
                k_d    = step_k;
                if (idx_q == IdxLast) begin
                    // The first emitted digit is the one being written now, so bypass the buffer.
                    state_d = StEmit;
                    digit_d = step_dig;
                    nz_d    = |step_dig;
                    last_d  = 1'b0;
                    valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            StEmit: begin
                if (hs) begin
                    if (idx_q == '0) begin
                        state_d = StDone;
                        valid_d = 1'b0;
                        digit_d = '0;
                        nz_d    = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        digit_d = buf_rd;
                        nz_d    = |buf_rd;
                        last_d  = idx_q == IW'(1);
                    end
                end
            end

            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            idx_q   <= '0;
            digit_q <= '0;
            valid_q <= 1'b0;
            nz_q    <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            idx_q   <= idx_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            nz_q    <= nz_d;
            last_q  <= last_d;
        end
    end

    assign bus.o_busy  = !can_start;
    assign bus.o_valid = valid_q;
    assign bus.o_digit = digit_q;
    assign bus.o_nz    = nz_q;
    assign bus.o_last  = last_q;
    assign bus.o_done  = state_q == StDone;

    // After the final step every bit of the scalar must have been consumed.
    logic          chk_en;
    logic [KW-1:0] chk_k;

    always_comb begin
        chk_en = 1'b0;
        chk_k  = k_q;
        if (state_q == StStream && hs && idx_q == IdxLast) begin
            chk_en = 1'b1;
        end
        if (state_q == StRecode && idx_q == IdxLast) begin
            chk_en = 1'b1;
            chk_k  = step_k;
        end
    end

    a_k_drained: assert property (@(posedge i_clk) disable iff (i_rst) chk_en |-> chk_k == '0);
endmodule
